// File: rtl/univ_bin_counter_monitor.sv
// Run-time checker for univ_bin_counter: a shadow model predicts q and flags divergence.
// Optional tick checking is enabled by defining UBC_MON_TICK_CHECK_EN.
module univ_bin_counter_monitor #(
  parameter int N     = 3,
  parameter int ERR_W = 8,
  parameter int HALT  = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             syn_clr,
  input  logic             load,
  input  logic             en,
  input  logic             up,
  input  logic [N-1:0]     d,
  input  logic [N-1:0]     q,
  input  logic             max_tick,
  input  logic             min_tick,
  input  logic             check_en,
  input  logic             resync,
  input  logic             clr_err,
  output logic [1:0]       state,
  output logic [N-1:0]     exp_q,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt,
  output logic [N-1:0]     first_exp_q,
  output logic [N-1:0]     first_obs_q
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    CHECK  = 2'b01,
    HALTED = 2'b10
  } state_t;

  state_t         state_q, state_nxt;
  logic [N-1:0]   exp_q_nxt;
  logic           do_check, q_fault, tick_fault, mismatch;

  // Same priority as the counter itself: syn_clr, then load, then count.
  function automatic logic [N-1:0] next_val(input logic [N-1:0] v, input logic sc,
                                            input logic ld, input logic e, input logic u,
                                            input logic [N-1:0] dv);
    if (sc)          return '0;
    else if (ld)     return dv;
    else if (e && u) return v + N'(1);
    else if (e)      return v - N'(1);
    else             return v;
  endfunction

  always_comb begin
    do_check = (state_q == CHECK) && check_en && !resync;
    q_fault  = (q != exp_q);
`ifdef UBC_MON_TICK_CHECK_EN
    tick_fault = (max_tick != (exp_q == '1)) || (min_tick != (exp_q == '0));
`else
    tick_fault = 1'b0;
`endif
    mismatch = do_check && (q_fault || tick_fault);
  end

`ifndef UBC_MON_TICK_CHECK_EN
  logic unused_ticks;
  assign unused_ticks = max_tick ^ min_tick;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      exp_q   <= '0;
    end else begin
      state_q <= state_nxt;
      exp_q   <= exp_q_nxt;
    end
  end

  // The model advances from its own prediction in CHECK, never from q.
  always_comb begin
    state_nxt = state_q;
    exp_q_nxt = exp_q;
    if (resync) begin
      state_nxt = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (check_en) begin
            state_nxt = CHECK;
            exp_q_nxt = next_val(q, syn_clr, load, en, up, d);
          end
        end
        CHECK: begin
          if (!check_en) begin
            state_nxt = IDLE;
          end else begin
            exp_q_nxt = next_val(exp_q, syn_clr, load, en, up, d);
            if (mismatch && (HALT != 0)) state_nxt = HALTED;
          end
        end
        HALTED:  state_nxt = HALTED;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // A mismatch on the same edge as clr_err counts as the first error after the clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err         <= 1'b0;
      err_cnt     <= '0;
      first_exp_q <= '0;
      first_obs_q <= '0;
    end else if (mismatch) begin
      err <= 1'b1;
      if (clr_err)           err_cnt <= ERR_W'(1);
      else if (err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
      if (!err || clr_err) begin
        first_exp_q <= exp_q;
        first_obs_q <= q;
      end
    end else if (clr_err) begin
      err         <= 1'b0;
      err_cnt     <= '0;
      first_exp_q <= '0;
      first_obs_q <= '0;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_univ_bin_counter_monitor.sv
// Directed bench for univ_bin_counter_monitor: one HALT=0 and one HALT=1 instance share stimulus.
module tb_univ_bin_counter_monitor;

  logic       clk = 1'b0;
  logic       reset_n, syn_clr, load, en, up, max_tick, min_tick, check_en, resync, clr_err;
  logic [2:0] d, q, cnt;
  logic [1:0] state0, state1;
  logic [2:0] exp_q0, exp_q1, fexp0, fexp1, fobs0, fobs1;
  logic       err0, err1;
  logic [7:0] err_cnt0, err_cnt1;
  int         n_checks = 0;
  int         n_fail   = 0;

  always #5 clk = ~clk;

  univ_bin_counter_monitor #(.N(3), .ERR_W(8), .HALT(0)) u0 (
    .clk(clk), .reset_n(reset_n), .syn_clr(syn_clr), .load(load), .en(en), .up(up),
    .d(d), .q(q), .max_tick(max_tick), .min_tick(min_tick), .check_en(check_en),
    .resync(resync), .clr_err(clr_err), .state(state0), .exp_q(exp_q0), .err(err0),
    .err_cnt(err_cnt0), .first_exp_q(fexp0), .first_obs_q(fobs0));

  univ_bin_counter_monitor #(.N(3), .ERR_W(8), .HALT(1)) u1 (
    .clk(clk), .reset_n(reset_n), .syn_clr(syn_clr), .load(load), .en(en), .up(up),
    .d(d), .q(q), .max_tick(max_tick), .min_tick(min_tick), .check_en(check_en),
    .resync(resync), .clr_err(clr_err), .state(state1), .exp_q(exp_q1), .err(err1),
    .err_cnt(err_cnt1), .first_exp_q(fexp1), .first_obs_q(fobs1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Emulates a healthy counter: apply controls, clock, then present the new count on q.
  task automatic drive_cycle(input logic sc, input logic ld, input logic e, input logic u,
                             input logic [2:0] dv);
    syn_clr = sc; load = ld; en = e; up = u; d = dv;
    tick();
    if (sc)          cnt = 3'd0;
    else if (ld)     cnt = dv;
    else if (e && u) cnt = cnt + 3'd1;
    else if (e)      cnt = cnt - 3'd1;
    q = cnt;
    max_tick = (cnt == 3'd7);
    min_tick = (cnt == 3'd0);
    syn_clr = 0; load = 0; en = 0; up = 0;
  endtask

  task automatic test_healthy();
    check_en = 1;
    drive_cycle(0, 0, 0, 0, 3'd0);
    n_checks++;
    if (state0 !== 2'b01) begin n_fail++; $display("[TB] FAIL acquire_state: got %0d want 1", state0); end
    drive_cycle(0, 1, 0, 0, 3'd3);
    n_checks++;
    if (exp_q0 !== 3'd3) begin n_fail++; $display("[TB] FAIL load3: got %0d want 3", exp_q0); end
    drive_cycle(1, 1, 1, 1, 3'd5);
    n_checks++;
    if (exp_q0 !== 3'd0) begin n_fail++; $display("[TB] FAIL syn_clr_wins: got %0d want 0", exp_q0); end
    for (int i = 0; i < 22; i++) begin
      if (i < 10)      drive_cycle(0, 0, 1, 1, 3'd0);
      else if (i < 12) drive_cycle(0, 0, 0, 0, 3'd0);
      else             drive_cycle(0, 0, 1, 0, 3'd0);
      n_checks++;
      if (exp_q0 !== q || err0 !== 1'b0 || err1 !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL healthy_%0d: exp_q=%0d err0=%b err1=%b want exp_q=%0d err=0",
                 i, exp_q0, err0, err1, q);
      end
    end
    n_checks++;
    if (cnt !== 3'd0 || exp_q1 !== 3'd0) begin
      n_fail++; $display("[TB] FAIL healthy_end: exp_q1=%0d want 0", exp_q1);
    end
  endtask

  task automatic test_fault();
    drive_cycle(0, 1, 0, 0, 3'd3);
    drive_cycle(0, 0, 1, 1, 3'd0);
    q = 3'd5;
    drive_cycle(0, 0, 0, 0, 3'd0);
    n_checks++;
    if (err0 !== 1'b1 || err_cnt0 !== 8'd1 || fexp0 !== 3'd4 || fobs0 !== 3'd5 || state0 !== 2'b01) begin
      n_fail++;
      $display("[TB] FAIL fault_capture: err=%b cnt=%0d fexp=%0d fobs=%0d st=%0d want 1 1 4 5 1",
               err0, err_cnt0, fexp0, fobs0, state0);
    end
    n_checks++;
    if (state1 !== 2'b10 || err1 !== 1'b1) begin
      n_fail++; $display("[TB] FAIL halt_entry: state=%0d err=%b want 2 1", state1, err1);
    end
    for (int i = 0; i < 3; i++) drive_cycle(0, 0, 1, 1, 3'd0);
    n_checks++;
    if (err_cnt0 !== 8'd1 || exp_q0 !== 3'd7) begin
      n_fail++; $display("[TB] FAIL after_fault: cnt=%0d exp_q=%0d want 1 7", err_cnt0, exp_q0);
    end
    n_checks++;
    if (exp_q1 !== 3'd4 || state1 !== 2'b10) begin
      n_fail++; $display("[TB] FAIL halted_frozen: exp_q=%0d state=%0d want 4 2", exp_q1, state1);
    end
  endtask

  task automatic test_halt_resync();
    resync = 1;
    drive_cycle(0, 0, 0, 0, 3'd0);
    resync = 0;
    n_checks++;
    if (state1 !== 2'b00 || state0 !== 2'b00) begin
      n_fail++; $display("[TB] FAIL resync_idle: s1=%0d s0=%0d want 0 0", state1, state0);
    end
    drive_cycle(0, 0, 1, 1, 3'd0);
    n_checks++;
    if (state1 !== 2'b01 || exp_q1 !== 3'd0 || err1 !== 1'b1) begin
      n_fail++; $display("[TB] FAIL reacquire: state=%0d exp_q=%0d err=%b want 1 0 1", state1, exp_q1, err1);
    end
    clr_err = 1;
    drive_cycle(0, 0, 0, 0, 3'd0);
    clr_err = 0;
    n_checks++;
    if (err0 !== 1'b0 || err_cnt0 !== 8'd0 || fexp0 !== 3'd0 || fobs0 !== 3'd0 || state0 !== 2'b01) begin
      n_fail++; $display("[TB] FAIL clr_err: err=%b cnt=%0d fexp=%0d fobs=%0d st=%0d want 0 0 0 0 1",
                         err0, err_cnt0, fexp0, fobs0, state0);
    end
  endtask

  task automatic test_wrap();
    drive_cycle(0, 1, 0, 0, 3'd7);
    drive_cycle(0, 0, 1, 1, 3'd0);
    n_checks++;
    if (exp_q0 !== 3'd0) begin n_fail++; $display("[TB] FAIL wrap_up: got %0d want 0", exp_q0); end
    drive_cycle(0, 0, 1, 0, 3'd0);
    n_checks++;
    if (exp_q0 !== 3'd7 || err0 !== 1'b0 || err1 !== 1'b0) begin
      n_fail++; $display("[TB] FAIL wrap_down: exp_q=%0d err0=%b err1=%b want 7 0 0", exp_q0, err0, err1);
    end
  endtask

  task automatic test_ticks();
    max_tick = 1'b0;
    drive_cycle(0, 0, 0, 0, 3'd0);
    n_checks++;
`ifdef UBC_MON_TICK_CHECK_EN
    if (err0 !== 1'b1 || err_cnt0 !== 8'd1) begin
      n_fail++; $display("[TB] FAIL tick_fault: err=%b cnt=%0d want 1 1", err0, err_cnt0);
    end
`else
    if (err0 !== 1'b0 || err_cnt0 !== 8'd0) begin
      n_fail++; $display("[TB] FAIL tick_ignored: err=%b cnt=%0d want 0 0", err0, err_cnt0);
    end
`endif
  endtask

  task automatic test_clr_same_edge();
    clr_err = 1;
    drive_cycle(0, 0, 0, 0, 3'd0);
    clr_err = 0;
    q = 3'd2;
    drive_cycle(0, 0, 0, 0, 3'd0);
    n_checks++;
    if (err_cnt0 !== 8'd1 || fobs0 !== 3'd2 || fexp0 !== 3'd7) begin
      n_fail++; $display("[TB] FAIL fault2: cnt=%0d fobs=%0d fexp=%0d want 1 2 7", err_cnt0, fobs0, fexp0);
    end
    q = 3'd5;
    clr_err = 1;
    drive_cycle(0, 0, 0, 0, 3'd0);
    clr_err = 0;
    n_checks++;
    if (err0 !== 1'b1 || err_cnt0 !== 8'd1 || fobs0 !== 3'd5 || fexp0 !== 3'd7) begin
      n_fail++; $display("[TB] FAIL clr_vs_mismatch: err=%b cnt=%0d fobs=%0d fexp=%0d want 1 1 5 7",
                         err0, err_cnt0, fobs0, fexp0);
    end
  endtask

  task automatic test_reset();
    #2;
    reset_n = 0;
    #1;
    n_checks++;
    if (state0 !== 2'b00 || exp_q0 !== 3'd0 || err0 !== 1'b0 || err_cnt0 !== 8'd0 ||
        fexp0 !== 3'd0 || fobs0 !== 3'd0) begin
      n_fail++; $display("[TB] FAIL async_reset0: st=%0d exp=%0d err=%b cnt=%0d fexp=%0d fobs=%0d want all 0",
                         state0, exp_q0, err0, err_cnt0, fexp0, fobs0);
    end
    n_checks++;
    if (state1 !== 2'b00 || exp_q1 !== 3'd0 || err1 !== 1'b0 || err_cnt1 !== 8'd0) begin
      n_fail++; $display("[TB] FAIL async_reset1: st=%0d exp=%0d err=%b cnt=%0d want all 0",
                         state1, exp_q1, err1, err_cnt1);
    end
    tick();
    reset_n = 1;
  endtask

  initial begin
    reset_n = 0; syn_clr = 0; load = 0; en = 0; up = 0; d = 0;
    cnt = 0; q = 0; max_tick = 0; min_tick = 1;
    check_en = 0; resync = 0; clr_err = 0;
    tick();
    tick();
    reset_n = 1;
    tick();
    test_healthy();
    test_fault();
    test_halt_resync();
    test_wrap();
    test_ticks();
    max_tick = (cnt == 3'd7);
    test_clr_same_edge();
    q = cnt;
    test_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
